// File: rtl/morse_char_queue.sv
// Character FIFO between the Morse decoder and the LCD driver, with cursor tracking and
// line-wrap DDRAM address commands. Define MORSE_QUEUE_BKSP_EN to expand 0x08 into an erase.
module morse_char_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned LINE_LEN    = 16,
  parameter int unsigned ACK_TIMEOUT = 1000,
  localparam int unsigned CntW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [7:0]      in_char_i,
  input  logic            in_send_i,
  input  logic            drv_busy_i,
  output logic [7:0]      out_char_o,
  output logic            out_rs_o,
  output logic            out_write_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o,
  output logic [CntW-1:0] count_o,
  output logic [4:0]      col_o,
  output logic            row_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StWrap
  } state_e;

  // What the transfer currently in flight was, so WAIT_DONE knows how to finish it.
  typedef enum logic [1:0] {
    XferChar,
    XferWrap,
    XferBksp
  } xfer_e;

  logic [7:0]      mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;

  state_e          state_q, state_d;
  xfer_e           xfer_q, xfer_d;
  logic [7:0]      out_char_q, out_char_d;
  logic            out_rs_q, out_rs_d;
  logic            out_write_q, out_write_d;
  logic [4:0]      col_q, col_d;
  logic            row_q, row_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
`ifdef MORSE_QUEUE_BKSP_EN
  logic [1:0]      bksp_step_q, bksp_step_d;
`endif

  logic       full, empty;
  logic       push_req, push, pop;
  logic [7:0] head;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign push_req = en_i & in_send_i;
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_char_i;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    out_char_d  = out_char_q;
    out_rs_d    = out_rs_q;
    out_write_d = 1'b0;
    col_d       = col_q;
    row_d       = row_q;
    ack_cnt_d   = ack_cnt_q;
    pop         = 1'b0;
`ifdef MORSE_QUEUE_BKSP_EN
    bksp_step_d = bksp_step_q;
`endif

    case (state_q)
      StIdle: begin
        if (en_i && !empty && !drv_busy_i) begin
          pop = 1'b1;
`ifdef MORSE_QUEUE_BKSP_EN
          if (head == 8'h08) begin
            // A backspace at column 0 is consumed silently.
            if (col_q != '0) begin
              out_char_d  = 8'h10;
              out_rs_d    = 1'b0;
              out_write_d = 1'b1;
              xfer_d      = XferBksp;
              bksp_step_d = 2'd0;
              state_d     = StIssue;
            end
          end else begin
            out_char_d  = head;
            out_rs_d    = 1'b1;
            out_write_d = 1'b1;
            xfer_d      = XferChar;
            state_d     = StIssue;
          end
`else
          out_char_d  = head;
          out_rs_d    = 1'b1;
          out_write_d = 1'b1;
          xfer_d      = XferChar;
          state_d     = StIssue;
`endif
        end
      end

      StIssue, StWrap: begin
        ack_cnt_d = '0;
        state_d   = StWaitAck;
      end

      StWaitAck: begin
        if (drv_busy_i || ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
          state_d = StWaitDone;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end

      StWaitDone: begin
        if (!drv_busy_i) begin
          case (xfer_q)
            XferChar: begin
              if (col_q < 5'(LINE_LEN - 1)) begin
                col_d   = col_q + 5'd1;
                state_d = StIdle;
              end else begin
                col_d       = '0;
                row_d       = ~row_q;
                out_char_d  = row_q ? 8'h80 : 8'hC0;
                out_rs_d    = 1'b0;
                out_write_d = 1'b1;
                xfer_d      = XferWrap;
                state_d     = StWrap;
              end
            end
`ifdef MORSE_QUEUE_BKSP_EN
            XferBksp: begin
              if (bksp_step_q == 2'd0) begin
                out_char_d  = 8'h20;
                out_rs_d    = 1'b1;
                out_write_d = 1'b1;
                bksp_step_d = 2'd1;
                state_d     = StIssue;
              end else if (bksp_step_q == 2'd1) begin
                out_char_d  = 8'h10;
                out_rs_d    = 1'b0;
                out_write_d = 1'b1;
                bksp_step_d = 2'd2;
                state_d     = StIssue;
              end else begin
                col_d   = col_q - 5'd1;
                state_d = StIdle;
              end
            end
`endif
            default: state_d = StIdle;
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      xfer_q      <= XferChar;
      out_char_q  <= '0;
      out_rs_q    <= 1'b0;
      out_write_q <= 1'b0;
      col_q       <= '0;
      row_q       <= 1'b0;
      ack_cnt_q   <= '0;
`ifdef MORSE_QUEUE_BKSP_EN
      bksp_step_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      out_char_q  <= out_char_d;
      out_rs_q    <= out_rs_d;
      out_write_q <= out_write_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ack_cnt_q   <= ack_cnt_d;
`ifdef MORSE_QUEUE_BKSP_EN
      bksp_step_q <= bksp_step_d;
`endif
    end
  end

  assign out_char_o  = out_char_q;
  assign out_rs_o    = out_rs_q;
  assign out_write_o = out_write_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = overflow_q;
  assign count_o     = count_q;
  assign col_o       = col_q;
  assign row_o       = row_q;

endmodule

// File: tb/tb_morse_char_queue.sv
// Randomized bench for morse_char_queue: an emulated LCD driver records every transfer and a
// queue-based model of the text/cursor rules predicts them.
module tb_morse_char_queue;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned LINE_LEN    = 16;
  localparam int unsigned ACK_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_send = 1'b0;
  logic       drv_busy;
  logic [7:0] out_char;
  logic       out_rs, out_write, full, empty, overflow;
  logic [3:0] count;
  logic [4:0] col;
  logic       row;

  logic force_busy = 1'b0;
  logic auto_busy  = 1'b0;
  assign drv_busy = force_busy | auto_busy;

  int drv_delay = 2;  // cycles from write to busy rise; 0 = driver never acknowledges
  int drv_len   = 3;
  int busy_cd   = 0;
  int busy_left = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         m_col = 0;
  int         m_row = 0;
  bit         m_ovf = 1'b0;

  always #5 clk = ~clk;

  morse_char_queue #(
    .DEPTH      (DEPTH),
    .LINE_LEN   (LINE_LEN),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .in_char_i  (in_char),
    .in_send_i  (in_send),
    .drv_busy_i (drv_busy),
    .out_char_o (out_char),
    .out_rs_o   (out_rs),
    .out_write_o(out_write),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow),
    .count_o    (count),
    .col_o      (col),
    .row_o      (row)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Emulated LCD driver: logs each write and answers with a busy pulse.
  initial forever begin
    @(negedge clk);
    if (busy_cd > 0) begin
      busy_cd--;
      if (busy_cd == 0) begin
        auto_busy = 1'b1;
        busy_left = drv_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) auto_busy = 1'b0;
    end
    if (out_write === 1'b1) begin
      got_q.push_back({out_rs, out_char});
      if (drv_delay > 0) busy_cd = drv_delay;
    end
  end

  // Text-level model: what the display should receive for one dequeued character.
  function automatic void model_emit(input logic [7:0] c);
`ifdef MORSE_QUEUE_BKSP_EN
    if (c == 8'h08) begin
      if (m_col > 0) begin
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h10});
        m_col--;
      end
      return;
    end
`endif
    exp_q.push_back({1'b1, c});
    if (m_col < LINE_LEN - 1) begin
      m_col++;
    end else begin
      m_col = 0;
      m_row ^= 1;
      exp_q.push_back({1'b0, (m_row == 1) ? 8'hC0 : 8'h80});
    end
  endfunction

  function automatic logic [7:0] rand_char();
    if ($urandom_range(0, 7) == 0) return 8'h08;
    return 8'($urandom_range(32, 126));
  endfunction

  // Called at a negedge; the push is sampled on the following posedge.
  task automatic send(input logic [7:0] c);
    in_char = c;
    in_send = 1'b1;
    @(negedge clk);
    in_send = 1'b0;
  endtask

  task automatic wait_quiet(input int quiet);
    int q = 0;
    for (int i = 0; i < 5000 && q < quiet; i++) begin
      @(negedge clk);
      if (out_write === 1'b0 && drv_busy === 1'b0 && empty === 1'b1) q++;
      else q = 0;
    end
    check_eq("drain", q, quiet);
  endtask

  task automatic compare_xfers(input string tag);
    int n;
    check_eq({tag, "_nxfer"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_xfer"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check_eq({tag, "_col"}, col, m_col);
    check_eq({tag, "_row"}, row, m_row);
    check_eq({tag, "_ovf"}, overflow, m_ovf);
    check_eq({tag, "_count"}, count, 0);
  endtask

  // With the driver forced busy nothing pops, so acceptance depends only on the burst size.
  task automatic burst(input int n, input string tag);
    logic [7:0] c;
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      c = rand_char();
      send(c);
      if (i < DEPTH) model_emit(c);
      else m_ovf = 1'b1;
    end
    check_eq({tag, "_cnt_full"}, count, (n < DEPTH) ? n : DEPTH);
    check_eq({tag, "_full"}, full, (n >= DEPTH) ? 1 : 0);
    check_eq({tag, "_ovf_now"}, overflow, m_ovf);
    force_busy = 1'b0;
    wait_quiet(2 * ACK_TIMEOUT + 10);
    compare_xfers(tag);
  endtask

  initial begin
    int found;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_char", out_char, 8'h00);
    check_eq("rst_rs", out_rs, 0);
    check_eq("rst_write", out_write, 0);
    check_eq("rst_col", col, 0);
    check_eq("rst_row", row, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // Two-cycle latency from a push into an empty queue to the write strobe.
    in_char = 8'h41;
    in_send = 1'b1;
    @(negedge clk);
    in_send = 1'b0;
    check_eq("lat_cycle1_write", out_write, 0);
    @(negedge clk);
    check_eq("lat_cycle2_write", out_write, 1);
    check_eq("lat_char", out_char, 8'h41);
    check_eq("lat_rs", out_rs, 1);
    model_emit(8'h41);
    wait_quiet(2 * ACK_TIMEOUT + 10);
    compare_xfers("first");

    // EN low: pushes ignored without overflow, queued data held until re-enabled.
    en = 1'b0;
    send(8'h33);
    check_eq("en_low_count", count, 0);
    check_eq("en_low_ovf", overflow, 0);
    force_busy = 1'b1;
    en         = 1'b1;
    send(8'h34);
    model_emit(8'h34);
    en         = 1'b0;
    force_busy = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("en_low_nowrite", got_q.size(), 0);
    check_eq("en_low_held", count, 1);
    en = 1'b1;
    wait_quiet(2 * ACK_TIMEOUT + 10);
    compare_xfers("en");

    burst(DEPTH + 1, "ovf");

    for (int b = 0; b < 14; b++) begin
      drv_delay = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
      drv_len   = int'($urandom_range(1, 4));
      burst(int'($urandom_range(3, DEPTH + 2)), "rand");
    end

    // Asynchronous reset while waiting for the driver to finish, with three queued.
    drv_delay = 1;
    drv_len   = 1;
    send(8'h55);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (out_write === 1'b1) found = 1;
      else @(negedge clk);
    end
    check_eq("rst_setup_write", found, 1);
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    check_eq("rst_setup_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_empty", empty, 1);
    check_eq("arst_ovf", overflow, 0);
    check_eq("arst_char", out_char, 8'h00);
    check_eq("arst_write", out_write, 0);
    check_eq("arst_col", col, 0);
    check_eq("arst_row", row, 0);
    force_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    m_ovf = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("post_rst_nowrite", got_q.size(), 0);
    send(8'h42);
    model_emit(8'h42);
    wait_quiet(2 * ACK_TIMEOUT + 10);
    compare_xfers("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_char_queue.md
Name: morse_char_queue

Overview:
- Buffers decoded ASCII characters from the Morse-to-character stage and feeds them, one per handshake, to the LCD driver FSM.
- Decouples bursty character strobes from the slow LCD write cycle.
- Tracks the cursor column and row.
- Inserts DDRAM set-address commands at line ends, so text wraps across a 2-line display instead of running off-screen.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- LINE_LEN, 16: visible characters per LCD row.
- ACK_TIMEOUT, 1000: cycles to wait for DRV_BUSY to rise before treating a transfer as accepted.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  block enable; low suspends both push and issue.
- IN_CHAR  in  8  ASCII character from the decoder.
- IN_SEND  in  1  one-cycle strobe; IN_CHAR is valid this cycle.
- DRV_BUSY  in  1  LCD driver busy (its WAITING|WRITING).
- OUT_CHAR  out  8  byte presented to the driver.
- OUT_RS  out  1  1 = data byte, 0 = command byte.
- OUT_WRITE  out  1  one-cycle transfer request.
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- OVERFLOW  out  1  sticky; a push was dropped.
- COUNT  out  $clog2(DEPTH)+1  occupancy.
- COL  out  5  cursor column, 0..LINE_LEN-1.
- ROW  out  1  cursor row.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs and state clear immediately.
  - FIFO empty, pointers 0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0.
  - OUT_CHAR=0x00, OUT_RS=0, OUT_WRITE=0, COL=0, ROW=0, FSM in IDLE.
  - A reset mid-transfer abandons the transfer. The driver is not told.
- Push rules:
  - A push occurs when IN_SEND=1 and EN=1.
  - It is accepted if COUNT<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and OVERFLOW sets.
  - OVERFLOW stays set until reset.
- Pointer and count arithmetic:
  - Pointers wrap modulo DEPTH.
  - On a simultaneous push and pop, COUNT is unchanged.
- Issue FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WRAP.
  - IDLE: if EN=1, EMPTY=0 and DRV_BUSY=0, go to ISSUE.
  - ISSUE (1 cycle):
    - Pop the head entry.
    - Set OUT_CHAR to the head, OUT_RS=1, OUT_WRITE=1.
    - Go to WAIT_ACK.
    - Latency from the push of a character into an empty FIFO to OUT_WRITE is 2 cycles, with the driver idle.
  - WAIT_ACK: wait for DRV_BUSY=1, then go to WAIT_DONE. After ACK_TIMEOUT cycles without it, go to WAIT_DONE anyway.
  - WAIT_DONE: on DRV_BUSY=0, advance the cursor.
    - If COL < LINE_LEN-1: COL+1, then go to IDLE.
    - Otherwise: COL=0, toggle ROW, go to WRAP.
  - WRAP:
    - Issue a command: OUT_RS=0, OUT_CHAR=0xC0 if the new ROW=1, else 0x80, with a one-cycle OUT_WRITE.
    - Then run the same WAIT_ACK/WAIT_DONE sequence, with no cursor advance, then go to IDLE.
    - Wrapping from row 1 returns to row 0 and overwrites it.
- OUT_CHAR and OUT_RS hold their value between transfers.
- EN low:
  - No new ISSUE starts.
  - A transfer already in progress completes.
  - Contents are retained.
  - IN_SEND is ignored; it does not count as an overflow.
- Non-printable codes are passed through as data, except 0x08 when the optional feature is enabled.

Optional Feature:
- Macro: MORSE_QUEUE_BKSP_EN.
- When defined, a popped 0x08 expands into three back-to-back transfers, each with the full handshake:
  - command 0x10 (cursor left);
  - data 0x20 (space);
  - command 0x10 (cursor left).
- After the expansion, COL decrements by 1.
- At COL=0 the 0x08 is discarded with no transfer. There is no backspace across rows.
- When not defined, 0x08 is written as an ordinary data byte and advances COL.

Test Plan:
- Push 0x41 into an empty queue, driver idle, DRV_BUSY pulses 3 cycles high 2 cycles after the write -> OUT_WRITE exactly 2 cycles after IN_SEND, with OUT_CHAR=0x41 and OUT_RS=1. Then COL=1 and EMPTY=1.
- Push 9 chars back-to-back with DRV_BUSY held high (DEPTH=8) -> FULL=1, COUNT=8, OVERFLOW=1, 9th char lost. Release busy -> 8 chars emitted in order.
- Write 16 chars on row 0 -> after the 16th, a command transfer 0xC0 with OUT_RS=0, then ROW=1, COL=0. A further 16 chars -> command 0x80, then ROW=0.
- DRV_BUSY never rises -> transfer completes after ACK_TIMEOUT cycles, and the next char issues.
- RST_N asserted in WAIT_DONE with COUNT=3 -> all outputs go to reset values asynchronously. No OUT_WRITE after release until a new push.
- With MORSE_QUEUE_BKSP_EN at COL=5 push 0x08 -> transfers 0x10(RS=0), 0x20(RS=1), 0x10(RS=0), then COL=4. At COL=0 push 0x08 -> no transfer.
